regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
//
// PURPOSE
// 32-entry x 32-bit register file with two read ports and one write port.
// It is the storage stage that directly feeds the 32:1 read muxes
// (mux32to1by32), with one mux instance per read port.
// Writes go through a 5:32 write-enable decoder into 32 clocked registers.
// Register 0 is hardwired to zero (MIPS convention).
//
// PARAMETERS
// BYPASS    0  1: a read of the register being written this cycle returns
//              WriteData combinationally; 0: returns the stored (old) value
// ZERO_REG  1  1: register 0 always reads 0 and ignores writes;
//              0: register 0 is an ordinary register
//
// PORTS
// clk            in   1   system clock; all writes on rising edge
// reset          in   1   asynchronous, active-high; clears all registers
// ReadRegister1  in   5   read port 1 address
// ReadRegister2  in   5   read port 2 address
// WriteRegister  in   5   write port address
// WriteData      in   32  data to write
// RegWrite       in   1   write enable, sampled at posedge clk
// ReadData1      out  32  contents of register ReadRegister1
// ReadData2      out  32  contents of register ReadRegister2
//
// BEHAVIOUR
// - Reset: on reset rising, all 32 registers go to 32'h0 immediately,
//   independent of clk.
//   - ReadData1/ReadData2 are 0 for every address while reset is high,
//     except the BYPASS=1 forward path when RegWrite=1 (see below).
// - Reset wins over a coincident posedge clk with RegWrite=1; no write occurs.
// - Write: at posedge clk with reset=0 and RegWrite=1, reg[WriteRegister]
//   <= WriteData.
//   - Exactly one register is enabled (one-hot decoder); all others hold.
//   - RegWrite=0: no register changes.
//   - With ZERO_REG=1, WriteRegister=0 is discarded. The decoder still
//     fires, but reg0 has no storage.
// - Read: purely combinational via the 32:1 muxes, zero cycles of latency.
//   - With BYPASS=0, a value written at edge N is visible after edge N
//     (same cycle after the edge settles). Before the edge, the old value.
//   - With BYPASS=1, when RegWrite=1 and ReadRegisterX==WriteRegister
//     (and not reg0 with ZERO_REG=1), ReadDataX=WriteData before the edge.
//     Both ports forward independently.
// - Both read ports may address the same register; they return identical data.
// - Reset deasserted mid-cycle: the first write takes effect at the next
//   posedge clk.
// - Out-of-range addresses do not exist (5 bits cover all 32 entries).
// - No X propagation after reset: every register is initialised.
//
// TESTING
// 1 Reset: assert reset, then read all 32 addresses on both ports
//   -> every read is 32'h0.
// 2 Write 32'hDEADBEEF to r5 with RegWrite=1, then one clk edge;
//   ReadRegister1=5 -> ReadData1=32'hDEADBEEF; r4 and r6 still read 0.
// 3 Write 32'hFFFFFFFF to r0, clk edge; ReadRegister2=0
//   -> ReadData2=0 (ZERO_REG=1).
// 4 Write 32'h12345678 to r31 with RegWrite=0, clk edge
//   -> r31 reads 0. Repeat with RegWrite=1 -> r31 reads 32'h12345678.
// 5 Write r7=32'hA5A5A5A5, then pulse reset between clk edges
//   -> ReadData1 (addr 7) drops to 0 without a clk edge.
//   Assert reset on the same edge as RegWrite=1 -> no write.
// 6 BYPASS=1 build: r9=32'h1; drive RegWrite=1, WriteRegister=9,
//   WriteData=32'h2, ReadRegister1=ReadRegister2=9
//   -> both ports read 32'h2 before the edge.
//   BYPASS=0 build -> both ports read 32'h1 until the edge.

Source files
------------

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//
// Purpose:
//   32-entry x 32-bit register file with two combinational read ports and one
//   clocked write port. A 5:32 one-hot decoder turns the write address into
//   per-register enables. Each read port is a 32:1 mux (mux32to1by32) over
//   the stored registers. An optional forward path returns the in-flight
//   write data on a read of the register being written.
//
// Parameters:
//   BYPASS    1: a read of the register being written this cycle returns
//                WriteData combinationally; 0: it returns the stored value
//   ZERO_REG  1: register 0 always reads 0 and discards writes;
//             0: register 0 is an ordinary register
//
// Ports:
//   clk            in   1   clock, writes on rising edge
//   reset          in   1   asynchronous active-high clear of all registers
//   ReadRegister1  in   5   read port 1 address
//   ReadRegister2  in   5   read port 2 address
//   WriteRegister  in   5   write port address
//   WriteData      in   32  data to write
//   RegWrite       in   1   write enable, sampled at posedge clk
//   ReadData1      out  32  contents of register ReadRegister1
//   ReadData2      out  32  contents of register ReadRegister2
// ----------------------------------------------------------------------------

// 32:1 mux selecting one 32-bit word out of 32.
module mux32to1by32 (
    input  logic [31:0][31:0] data_i,
    input  logic [4:0]        sel_i,
    output logic [31:0]       data_o
);

    assign data_o = data_i[sel_i];

endmodule

module regfile_2r1w #(
    parameter bit BYPASS   = 1'b0,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [4:0]  WriteRegister,
    input  logic [31:0] WriteData,
    input  logic        RegWrite,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    logic [31:0]       writeEnable;
    logic [31:0][31:0] regs_q;
    logic [31:0][31:0] regs_d;
    logic [31:0]       muxOut1;
    logic [31:0]       muxOut2;
    logic              forward1;
    logic              forward2;

    // One-hot write-enable decoder: exactly one enable when RegWrite is high.
    always_comb begin
        writeEnable = '0;
        if (RegWrite) begin
            writeEnable[WriteRegister] = 1'b1;
        end
    end

    // Next-state for every register. With ZERO_REG the decoder may still
    // select entry 0, but that entry is tied to zero and so has no storage.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < 32; i++) begin
            if (writeEnable[i]) begin
                regs_d[i] = WriteData;
            end
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    // Storage. Reset clears everything immediately and takes priority over
    // a coincident clock edge, so a write on that edge is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    mux32to1by32 u_readMux1 (
        .data_i (regs_q),
        .sel_i  (ReadRegister1),
        .data_o (muxOut1)
    );

    mux32to1by32 u_readMux2 (
        .data_i (regs_q),
        .sel_i  (ReadRegister2),
        .data_o (muxOut2)
    );

    // Forward path: a pending write to the addressed register is visible
    // before the edge. Register 0 never forwards when it is hardwired.
    always_comb begin
        forward1 = 1'b0;
        forward2 = 1'b0;
        if (BYPASS && RegWrite) begin
            forward1 = (ReadRegister1 == WriteRegister) &&
                       !(ZERO_REG && (ReadRegister1 == 5'd0));
            forward2 = (ReadRegister2 == WriteRegister) &&
                       !(ZERO_REG && (ReadRegister2 == 5'd0));
        end
    end

    assign ReadData1 = forward1 ? WriteData : muxOut1;
    assign ReadData2 = forward2 ? WriteData : muxOut2;

endmodule

// File: tb/tb_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Purpose:
//   Self-checking bench for regfile_2r1w. Two instances share all inputs:
//   one with the default parameters (no forwarding, hardwired r0) and one
//   with BYPASS=1. A directed vector table, hand-written reset and forwarding
//   sequences, and a random phase checked against an array model exercise
//   both instances.
// ----------------------------------------------------------------------------
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] rdA1, rdA2;
    logic [31:0] rdB1, rdB2;

    int total = 0;
    int bad   = 0;

    // Reference contents of the register file (entry 0 never written).
    logic [31:0] model [32];

    typedef struct {
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [31:0] writeData;
        logic [4:0]  read1;
        logic [4:0]  read2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vecT;

    vecT vecs [7];

    regfile_2r1w dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (readReg1),
        .ReadRegister2 (readReg2),
        .WriteRegister (writeReg),
        .WriteData     (writeData),
        .RegWrite      (regWrite),
        .ReadData1     (rdA1),
        .ReadData2     (rdA2)
    );

    regfile_2r1w #(.BYPASS(1'b1), .ZERO_REG(1'b1)) dutByp (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (readReg1),
        .ReadRegister2 (readReg2),
        .WriteRegister (writeReg),
        .WriteData     (writeData),
        .RegWrite      (regWrite),
        .ReadData1     (rdB1),
        .ReadData2     (rdB2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one write/read vector at the falling edge, let the rising edge
    // commit it, and leave the inputs stable for post-edge sampling.
    task automatic applyStimulus(input vecT v);
        @(negedge clk);
        regWrite  = v.regWrite;
        writeReg  = v.writeReg;
        writeData = v.writeData;
        readReg1  = v.read1;
        readReg2  = v.read2;
        @(posedge clk);
        #1;
        if (v.regWrite && v.writeReg != 5'd0) begin
            model[v.writeReg] = v.writeData;
        end
    endtask

    initial begin
        logic [31:0] expB1, expB2;

        reset     = 1'b1;
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        readReg1  = '0;
        readReg2  = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset: every address reads zero on both ports of both builds.
        #2;
        for (int a = 0; a < 32; a++) begin
            readReg1 = 5'(a);
            readReg2 = 5'(31 - a);
            #1;
            checkOutput($sformatf("reset rd1 a=%0d", a), rdA1, 32'h0);
            checkOutput($sformatf("reset rd2 a=%0d", 31 - a), rdA2, 32'h0);
            checkOutput($sformatf("reset byp rd1 a=%0d", a), rdB1, 32'h0);
            checkOutput($sformatf("reset byp rd2 a=%0d", 31 - a), rdB2, 32'h0);
        end

        // While reset is high the forward path still returns WriteData.
        regWrite  = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'hCAFE0003;
        readReg1  = 5'd3;
        readReg2  = 5'd4;
        #1;
        checkOutput("reset fwd byp rd1", rdB1, 32'hCAFE0003);
        checkOutput("reset fwd byp rd2", rdB2, 32'h0);
        checkOutput("reset fwd nobyp rd1", rdA1, 32'h0);
        regWrite = 1'b0;

        @(negedge clk);
        reset = 1'b0;

        // Directed vectors; expected values are post-edge reads.
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd4,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd31, 32'h12345678, 5'd31, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 32'h12345678, 32'h12345678};
        vecs[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'h12345678};

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d rd1", i), rdA1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d rd2", i), rdA2, vecs[i].exp2);
            checkOutput($sformatf("vec%0d byp rd1", i), rdB1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d byp rd2", i), rdB2, vecs[i].exp2);
        end

        // Reset pulse between clock edges clears r7 without a clock edge.
        @(negedge clk);
        regWrite = 1'b0;
        readReg1 = 5'd7;
        readReg2 = 5'd31;
        #1;
        checkOutput("pre-pulse r7", rdA1, 32'hA5A5A5A5);
        reset = 1'b1;
        #1;
        checkOutput("async clear r7", rdA1, 32'h0);
        checkOutput("async clear r31", rdA2, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset held across an edge with RegWrite=1: the write is lost.
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'h00000055;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset beats write", rdA1, 32'h0);

        // Reset released mid-cycle: the next edge performs the write.
        @(negedge clk);
        regWrite  = 1'b1;
        writeData = 32'h00000077;
        @(posedge clk);
        #1;
        model[7] = 32'h00000077;
        checkOutput("write after reset", rdA1, 32'h00000077);

        // Forwarding: r9=1, then a pending write of 2 to r9.
        @(negedge clk);
        writeReg  = 5'd9;
        writeData = 32'h1;
        @(posedge clk);
        #1;
        model[9] = 32'h1;
        @(negedge clk);
        writeData = 32'h2;
        readReg1  = 5'd9;
        readReg2  = 5'd9;
        #1;
        checkOutput("fwd byp rd1", rdB1, 32'h2);
        checkOutput("fwd byp rd2", rdB2, 32'h2);
        checkOutput("nofwd rd1", rdA1, 32'h1);
        checkOutput("nofwd rd2", rdA2, 32'h1);
        @(posedge clk);
        #1;
        model[9] = 32'h2;
        checkOutput("post-edge rd1", rdA1, 32'h2);
        checkOutput("post-edge rd2", rdA2, 32'h2);

        // A pending write to r0 is never forwarded.
        @(negedge clk);
        writeReg  = 5'd0;
        writeData = 32'hFFFF0000;
        readReg1  = 5'd0;
        #1;
        checkOutput("r0 no fwd byp", rdB1, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("r0 stays zero", rdA1, 32'h0);

        // Random phase against the array model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            regWrite  = ($urandom_range(0, 3) != 0);
            writeReg  = 5'($urandom_range(0, 31));
            writeData = $urandom;
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg2  = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
            #1;
            expB1 = (regWrite && readReg1 == writeReg && readReg1 != 5'd0) ? writeData : model[readReg1];
            expB2 = (regWrite && readReg2 == writeReg && readReg2 != 5'd0) ? writeData : model[readReg2];
            checkOutput($sformatf("rand%0d pre rd1", n), rdA1, model[readReg1]);
            checkOutput($sformatf("rand%0d pre rd2", n), rdA2, model[readReg2]);
            checkOutput($sformatf("rand%0d pre byp rd1", n), rdB1, expB1);
            checkOutput($sformatf("rand%0d pre byp rd2", n), rdB2, expB2);
            @(posedge clk);
            #1;
            if (regWrite && writeReg != 5'd0) model[writeReg] = writeData;
            checkOutput($sformatf("rand%0d post rd1", n), rdA1, model[readReg1]);
            checkOutput($sformatf("rand%0d post rd2", n), rdA2, model[readReg2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
